// File: rtl/mul_pkg.sv
// Shared types and helpers for the schoolbook multiply row scheduler.
// Holds the limb-count helper, the scheduler state encoding and the valid-pipe record.
package mul_pkg;

  localparam int unsigned DESIRED_SIZE_DEF = 2080;
  localparam int unsigned PAD_W            = $clog2(DESIRED_SIZE_DEF) + 1;

  function automatic int unsigned num_words(input int unsigned nbits,
                                            input int unsigned rsize);
    return nbits / rsize;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    ISSUE,
    FLUSH,
    WAIT_LOW
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [PAD_W-1:0] padding;
  } pipe_t;

endpackage

// File: rtl/limb_mult.sv
// Registered unsigned limb multiplier with clock enable.
// Kept separate so the DSP mapping can be swapped without touching the scheduler.
module limb_mult #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] p_o
);

  logic [2*WIDTH-1:0] p_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= (2*WIDTH)'(a_i) * (2*WIDTH)'(b_i);
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/mul_row_scheduler.sv
// Streams every a[i]*b[j] limb product, row by row, into the shift-and-accumulate
// store, pacing rows against the store's ready handshake and flagging mid-row drops.
module mul_row_scheduler
  import mul_pkg::*;
#(
  parameter  int unsigned REGISTER_SIZE = 32,
  parameter  int unsigned NUM_BITS      = 2048,
  parameter  int unsigned DESIRED_SIZE  = 2080,
  localparam int unsigned NUM_WORDS     = num_words(NUM_BITS, REGISTER_SIZE),
  localparam int unsigned AW            = $clog2(NUM_WORDS),
  localparam int unsigned PW            = $clog2(DESIRED_SIZE) + 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  output logic [AW-1:0]            a_addr_out,
  input  logic [REGISTER_SIZE-1:0] a_data_in,
  output logic [AW-1:0]            b_addr_out,
  input  logic [REGISTER_SIZE-1:0] b_data_in,
  input  logic                     store_ready_in,
  output logic                     store_valid_out,
  output logic [REGISTER_SIZE-1:0] high_out,
  output logic [REGISTER_SIZE-1:0] low_out,
  output logic [PW-1:0]            padding_out,
  output logic                     busy_out,
  output logic                     row_done_out,
  output logic                     done_out,
  output logic                     error_out
);

  localparam logic [AW-1:0] LAST = AW'(NUM_WORDS - 1);

  state_e                     state_q, state_d;
  logic   [AW-1:0]            row_q, row_d;
  logic   [AW-1:0]            col_q, col_d;
  logic                       flush_q, flush_d;
  pipe_t                      s1_q, s1_d;
  pipe_t                      s2_q, s2_d;
  logic                       row_done_q, row_done_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic [2*REGISTER_SIZE-1:0] product;

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    col_d          = col_q;
    flush_d        = flush_q;
    err_d          = err_q;
    row_done_d     = 1'b0;
    done_d         = 1'b0;
    s1_d.valid     = 1'b0;
    s1_d.padding   = PAD_W'(row_q);
    s2_d           = s1_q;

    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = WAIT_READY;
          row_d   = '0;
        end
      end
      WAIT_READY: begin
        if (store_ready_in) begin
          state_d = ISSUE;
          col_d   = '0;
        end
      end
      ISSUE: begin
        // The store has no per-word ready, so a drop here aborts the whole multiply.
        if (!store_ready_in) begin
          err_d   = 1'b1;
          s2_d    = '0;
          state_d = IDLE;
        end else begin
          s1_d.valid = 1'b1;
          if (col_q == LAST) begin
            state_d = FLUSH;
            flush_d = 1'b0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (!flush_q) begin
          flush_d = 1'b1;
        end else begin
          row_done_d = 1'b1;
          if (row_q == LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = WAIT_LOW;
          end
        end
      end
      WAIT_LOW: begin
        if (!store_ready_in) begin
          state_d = WAIT_READY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      flush_q    <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      row_done_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      flush_q    <= flush_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      row_done_q <= row_done_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  limb_mult #(
    .WIDTH (REGISTER_SIZE)
  ) u_limb_mult (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .en_i  (s1_q.valid),
    .a_i   (a_data_in),
    .b_i   (b_data_in),
    .p_o   (product)
  );

  assign a_addr_out      = col_q;
  assign b_addr_out      = row_q;
  assign store_valid_out = s2_q.valid;
  assign high_out        = product[2*REGISTER_SIZE-1:REGISTER_SIZE];
  assign low_out         = product[REGISTER_SIZE-1:0];
  assign padding_out     = PW'(s2_q.padding);
  assign busy_out        = (state_q != IDLE);
  assign row_done_out    = row_done_q;
  assign done_out        = done_q;
  assign error_out       = err_q;

endmodule

// File: tb/tb_mul_row_scheduler.sv
// Bench for mul_row_scheduler at R=8, 32-bit operands: table vectors, random operands
// against a limb-product queue model, and hand sequences for abort/reset/stall cases.
module tb_mul_row_scheduler;

  localparam int unsigned R  = 8;
  localparam int unsigned NB = 32;
  localparam int unsigned DS = 2080;
  localparam int unsigned NW = NB / R;
  localparam int unsigned AW = $clog2(NW);
  localparam int unsigned PW = $clog2(DS) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] a_addr, b_addr;
  logic [R-1:0]  a_data, b_data;
  logic          ready = 1'b1;
  logic          valid;
  logic [R-1:0]  high, low;
  logic [PW-1:0] pad;
  logic          busy, row_done, done, err;

  always #5 clk = ~clk;

  mul_row_scheduler #(
    .REGISTER_SIZE (R),
    .NUM_BITS      (NB),
    .DESIRED_SIZE  (DS)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start),
    .a_addr_out      (a_addr),
    .a_data_in       (a_data),
    .b_addr_out      (b_addr),
    .b_data_in       (b_data),
    .store_ready_in  (ready),
    .store_valid_out (valid),
    .high_out        (high),
    .low_out         (low),
    .padding_out     (pad),
    .busy_out        (busy),
    .row_done_out    (row_done),
    .done_out        (done),
    .error_out       (err)
  );

  // Synchronous-read operand memories: data follows the address by one cycle.
  logic [R-1:0] mem_a [NW];
  logic [R-1:0] mem_b [NW];
  always @(posedge clk) begin
    a_data <= mem_a[a_addr];
    b_data <= mem_b[b_addr];
  end

  typedef struct {
    int unsigned  pad;
    logic [2*R-1:0] prod;
  } exp_t;

  typedef struct {
    logic [NB-1:0]  a;
    logic [NB-1:0]  b;
    logic [2*R-1:0] p_first;
    logic [2*R-1:0] p_last;
    bit             hold;
    int unsigned    lowlen;
  } vec_t;

  exp_t           exp_q[$];
  exp_t           e;
  vec_t           vecs[5];
  int             n_checks = 0;
  int             n_fail   = 0;
  int unsigned    n_words, n_done, n_rowdone, run_len;
  int unsigned    s_cnt, low_left, low_len;
  logic [2*R-1:0] first_prod, last_prod;
  bit             store_auto = 1'b0;
  bit             inject     = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({a_addr, b_addr, valid, high, low, pad, busy, row_done, done, err});
  endfunction

  // Reference: every a[i]*b[j] limb product, rows by j, columns by i.
  task automatic build_model(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int unsigned ai, bj;
    exp_q.delete();
    for (int j = 0; j < NW; j++) begin
      for (int i = 0; i < NW; i++) begin
        ai = 32'((a >> (R * i)) & 32'((1 << R) - 1));
        bj = 32'((b >> (R * j)) & 32'((1 << R) - 1));
        exp_q.push_back('{pad: j, prod: (2*R)'(ai * bj)});
      end
    end
  endtask

  task automatic prep(input logic [NB-1:0] a, input logic [NB-1:0] b, input int unsigned lowlen);
    for (int i = 0; i < NW; i++) begin
      mem_a[i] = a[R*i +: R];
      mem_b[i] = b[R*i +: R];
    end
    build_model(a, b);
    n_words = 0; n_done = 0; n_rowdone = 0; run_len = 0;
    s_cnt = 0; low_left = 0; low_len = lowlen;
    first_prod = '0; last_prod = '0;
    store_auto = 1'b1;
    ready = 1'b1;
  endtask

  // Store model and output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (n_words == 0) first_prod = {high, low};
        last_prod = {high, low};
        n_words++;
        run_len++;
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("product", {pad, high, low}, {PW'(e.pad), e.prod});
        end
      end else if (run_len != 0) begin
        check("row_burst_len", run_len, NW);
        run_len = 0;
      end
      if (done) n_done++;
      if (row_done) n_rowdone++;
      if (inject && busy && a_addr == AW'(1) && b_addr == AW'(1)) begin
        store_auto = 1'b0;
        ready = 1'b0;
      end
      if (store_auto) begin
        if (valid) begin
          if (s_cnt == NW - 1) begin
            s_cnt = 0;
            low_left = low_len;
            ready = 1'b0;
          end else begin
            s_cnt++;
          end
        end else if (low_left != 0) begin
          low_left--;
          if (low_left == 0) ready = 1'b1;
        end
      end
    end
  end

  task automatic wait_done(input bit hold);
    int unsigned busy_low;
    bit ok;
    busy_low = 0;
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) start = 1'b0;
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (!busy) busy_low++;
    end
    start = 1'b0;
    check("done_timeout", ok, 1);
    check("busy_during_run", busy_low, 0);
  endtask

  task automatic finish_checks(input logic [2*R-1:0] p_first, input logic [2*R-1:0] p_last,
                               input bit exp_err);
    repeat (12) @(negedge clk);
    check("word_count", n_words, NW * NW);
    check("queue_drained", exp_q.size(), 0);
    check("done_pulses", n_done, 1);
    check("row_done_pulses", n_rowdone, NW);
    check("first_product", first_prod, p_first);
    check("last_product", last_prod, p_last);
    check("idle_after_run", busy, 0);
    check("error_flag", err, exp_err);
  endtask

  initial begin
    logic [NB-1:0]  ra, rb;
    logic [2*R-1:0] pf, pl;
    int unsigned    bad, busy_low, lat;
    bit             ok;

    vecs[0] = '{a: 32'h04030201, b: 32'h08070605, p_first: 16'h0005, p_last: 16'h0020, hold: 1'b0, lowlen: 3};
    vecs[1] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, p_first: 16'hFE01, p_last: 16'hFE01, hold: 1'b0, lowlen: 3};
    vecs[2] = '{a: 32'h00000000, b: 32'h12345678, p_first: 16'h0000, p_last: 16'h0000, hold: 1'b0, lowlen: 2};
    vecs[3] = '{a: 32'h80000001, b: 32'h00000080, p_first: 16'h0080, p_last: 16'h0000, hold: 1'b0, lowlen: 4};
    vecs[4] = '{a: 32'h04030201, b: 32'h08070605, p_first: 16'h0005, p_last: 16'h0020, hold: 1'b1, lowlen: 5};

    #1 rst = 1'b1;
    #1 check("reset_outputs", outs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      prep(vecs[k].a, vecs[k].b, vecs[k].lowlen);
      @(negedge clk);
      start = 1'b1;
      wait_done(vecs[k].hold);
      finish_checks(vecs[k].p_first, vecs[k].p_last, 1'b0);
    end

    for (int r = 0; r < 4; r++) begin
      ra = $urandom;
      rb = $urandom;
      prep(ra, rb, $urandom_range(2, 6));
      pf = exp_q[0].prod;
      pl = exp_q[NW*NW-1].prod;
      @(negedge clk);
      start = 1'b1;
      wait_done(1'b0);
      finish_checks(pf, pl, 1'b0);
    end

    // Store drops ready on the second issue of row 1.
    prep(32'h04030201, 32'h08070605, 3);
    inject = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (err) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("error_timeout", ok, 1);
    @(negedge clk);
    check("valid_killed", valid, 0);
    check("idle_after_error", busy, 0);
    repeat (20) @(negedge clk);
    check("error_sticky", err, 1);
    check("no_done_after_error", n_done, 0);
    check("words_before_error", n_words, NW);
    inject = 1'b0;

    // A fresh start after the abort runs normally but leaves the error flag set.
    prep(32'h04030201, 32'h08070605, 3);
    @(negedge clk); start = 1'b1;
    wait_done(1'b0);
    finish_checks(16'h0005, 16'h0020, 1'b1);

    // Asynchronous reset in the middle of row 2.
    prep(32'hA5A5A5A5, 32'h5A5A5A5A, 3);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (busy && b_addr == AW'(2) && a_addr == AW'(1)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("reach_row2", ok, 1);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", outs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    prep(32'h04030201, 32'h08070605, 3);
    @(negedge clk); start = 1'b1;
    wait_done(1'b0);
    finish_checks(16'h0005, 16'h0020, 1'b0);

    // Store not ready for 50 cycles before row 0.
    prep(32'h0F0E0D0C, 32'h03020110, 3);
    store_auto = 1'b0;
    ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    bad = 0;
    busy_low = 0;
    repeat (50) begin
      @(negedge clk);
      if (valid) bad++;
      if (!busy) busy_low++;
    end
    check("no_valid_while_stalled", bad, 0);
    check("busy_while_stalled", busy_low, 0);
    ready = 1'b1;
    store_auto = 1'b1;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (valid) begin lat = c; break; end
    end
    check("ready_to_first_valid", lat, 3);
    wait_done(1'b1);
    finish_checks(16'h00C0, 16'h002D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
